// File: rtl/arb_mux.sv
// N-channel arbiter/mux with a one-deep registered output stage.
// Channel selection is either direct (sel) or round-robin starting after the last accepted channel.

module arb_mux_lane #(
    parameter int SELW = 2,
    parameter int IDX  = 0
) (
    input  logic            reset,
    input  logic            gnt,
    input  logic [SELW-1:0] gidx,
    input  logic            load,
    output logic            ready
);
    // reset gating keeps every ready low while the block is held in reset
    assign ready = gnt && load && !reset && (gidx == SELW'(IDX));
endmodule

module arb_mux #(
    parameter  int WIDTH = 64,
    parameter  int N     = 32,
    localparam int SELW  = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [N-1:0]              in_valid,
    input  logic [N-1:0][WIDTH-1:0]   in_data,
    output logic [N-1:0]              in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_src
);
    logic            load;
    logic            gnt;
    logic [SELW-1:0] gidx;
    logic [SELW-1:0] ptr;
    logic            rr_hit;
    logic [SELW-1:0] rr_idx;
    logic [SELW:0]   cand;

    assign load = !out_valid || out_ready;

    // Walk from farthest to nearest so the channel closest after ptr wins;
    // ptr never exceeds N-1, so one subtraction gives the modulo.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        cand   = '0;
        for (int k = N; k >= 1; k--) begin
            cand = {1'b0, ptr} + (SELW+1)'(k);
            if (cand >= (SELW+1)'(N))
                cand = cand - (SELW+1)'(N);
            if (in_valid[cand[SELW-1:0]]) begin
                rr_hit = 1'b1;
                rr_idx = cand[SELW-1:0];
            end
        end
    end

    always_comb begin
        gnt  = 1'b0;
        gidx = '0;
        if (mode) begin
            gnt  = rr_hit;
            gidx = rr_idx;
        end else if ({1'b0, sel} < (SELW+1)'(N)) begin
            gnt  = in_valid[sel];
            gidx = sel;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        arb_mux_lane #(.SELW(SELW), .IDX(i)) u_lane (
            .reset (reset),
            .gnt   (gnt),
            .gidx  (gidx),
            .load  (load),
            .ready (in_ready[i])
        );
    end

    // A grant always implies in_valid[gidx], so gnt && load is the input handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= SELW'(N-1);
        end else if (load) begin
            out_valid <= gnt;
            if (gnt) begin
                out_data <= in_data[gidx];
                out_src  <= gidx;
                ptr      <= gidx;
            end
        end
    end
endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: directed scenarios plus a randomized run, beats checked through a scoreboard.
module tb_arb_mux;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            mode;
    logic [1:0]      sel;
    logic [3:0]      in_valid;
    logic [3:0][7:0] in_data;
    logic [3:0]      in_ready;
    logic            out_valid, out_ready;
    logic [7:0]      out_data;
    logic [1:0]      out_src;

    logic            mode5;
    logic [2:0]      sel5;
    logic [4:0]      v5;
    logic [4:0][7:0] d5;
    logic [4:0]      r5;
    logic            ov5, or5;
    logic [7:0]      od5;
    logic [2:0]      os5;

    logic [9:0] sb[$];
    logic [9:0] sb_exp;
    int cmp = 0;
    int err = 0;

    arb_mux #(.WIDTH(8), .N(4)) dut (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_src(out_src)
    );

    arb_mux #(.WIDTH(8), .N(5)) dut5 (
        .clk(clk), .reset(reset), .mode(mode5), .sel(sel5), .in_valid(v5),
        .in_data(d5), .in_ready(r5), .out_valid(ov5),
        .out_ready(or5), .out_data(od5), .out_src(os5)
    );

    // scoreboard: a beat is consumed when out_valid && out_ready at the sampling point
    always @(negedge clk) begin
        #2;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            cmp++;
            if (sb.size() == 0) begin
                err++;
                $display("FAIL sb_beat: got src=%0d data=%h, required no beat", out_src, out_data);
            end else begin
                sb_exp = sb.pop_front();
                if ({out_src, out_data} !== sb_exp) begin
                    err++;
                    $display("FAIL sb_beat: got src=%0d data=%h, required src=%0d data=%h",
                             out_src, out_data, sb_exp[9:8], sb_exp[7:0]);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        mode5 = 1'b1; v5 = 5'h1F; or5 = 1'b1;
        sb.delete();
        for (int c = 0; c < 2; c++) begin
            #1;
            cmp++;
            if ({out_valid, out_data, out_src} !== 11'd0) begin
                err++;
                $display("FAIL reset_out: got v=%b d=%h s=%0d, required 0/00/0", out_valid, out_data, out_src);
            end
            cmp++;
            if (in_ready !== 4'b0 || r5 !== 5'b0) begin
                err++;
                $display("FAIL reset_ready: got %b/%b, required 0000/00000", in_ready, r5);
            end
            @(negedge clk);
        end
        reset = 1'b0; in_valid = '0; v5 = '0;
    endtask

    task automatic test_direct();
        @(negedge clk);
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = '0; in_data[2] = 8'hA5; out_ready = 1'b1;
        #1;
        cmp++;
        if (in_ready !== 4'b0100) begin
            err++; $display("FAIL direct_ready: got %b, required 0100", in_ready);
        end
        sb.push_back({2'd2, 8'hA5});
        @(negedge clk);
        sel = 2'd0; in_valid = 4'b1110;
        #1;
        cmp++;
        if ({out_valid, out_data, out_src} !== {1'b1, 8'hA5, 2'd2}) begin
            err++; $display("FAIL direct_out: got v=%b d=%h s=%0d, required 1/a5/2", out_valid, out_data, out_src);
        end
        cmp++;
        if (in_ready !== 4'b0) begin
            err++; $display("FAIL direct_novalid: got %b, required 0000", in_ready);
        end
        @(negedge clk);
        in_valid = '0;
        #1;
        cmp++;
        if ({out_valid, out_data, out_src} !== {1'b0, 8'hA5, 2'd2}) begin
            err++; $display("FAIL direct_drain: got v=%b d=%h s=%0d, required 0/a5/2", out_valid, out_data, out_src);
        end
    endtask

    task automatic test_rr();
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        logic [3:0] er;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
            for (int j = 0; j < 4; j++) in_data[j] = 8'h10 + 8'(j);
            #1;
            er = 4'b0001 << seq[i];
            cmp++;
            if (in_ready !== er) begin
                err++; $display("FAIL rr_seq[%0d]: got %b, required %b", i, in_ready, er);
            end
            sb.push_back({2'(seq[i]), 8'h10 + 8'(seq[i])});
        end
        @(negedge clk);
        in_valid = '0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data[1] = 8'h3C; out_ready = 1'b1;
        #1;
        cmp++;
        if (in_ready !== 4'b0010) begin
            err++; $display("FAIL bp_load: got %b, required 0010", in_ready);
        end
        sb.push_back({2'd1, 8'h3C});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0; mode = 1'($urandom); sel = 2'($urandom);
            in_valid = 4'($urandom) | 4'b0001; in_data = $urandom;
            #1;
            cmp++;
            if ({out_valid, out_data, out_src, in_ready} !== {1'b1, 8'h3C, 2'd1, 4'b0}) begin
                err++; $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d rdy=%b, required 1/3c/1/0000",
                                i, out_valid, out_data, out_src, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1; mode = 1'b0; sel = 2'd3; in_valid = 4'b1000; in_data[3] = 8'h77;
        #1;
        cmp++;
        if (in_ready !== 4'b1000) begin
            err++; $display("FAIL bp_release: got %b, required 1000", in_ready);
        end
        sb.push_back({2'd3, 8'h77});
        @(negedge clk);
        in_valid = '0;
        #1;
        cmp++;
        if ({out_valid, out_data, out_src} !== {1'b1, 8'h77, 2'd3}) begin
            err++; $display("FAIL bp_next: got v=%b d=%h s=%0d, required 1/77/3", out_valid, out_data, out_src);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] vs[7] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0100, 4'b0100, 4'b0100};
        logic [3:0] rs[7] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100};
        int         gs[7] = '{0, 1, 0, 1, 2, 2, 2};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            mode = 1'b1; in_valid = vs[i]; out_ready = 1'b1;
            for (int j = 0; j < 4; j++) in_data[j] = 8'h20 + 8'(i * 4 + j);
            #1;
            cmp++;
            if (in_ready !== rs[i]) begin
                err++; $display("FAIL wrap[%0d]: got %b, required %b", i, in_ready, rs[i]);
            end
            sb.push_back({2'(gs[i]), 8'h20 + 8'(i * 4 + gs[i])});
        end
        @(negedge clk);
        in_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
            for (int j = 0; j < 4; j++) in_data[j] = 8'h40 + 8'(j);
            sb.push_back({2'(i), 8'h40 + 8'(i)});
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        cmp++;
        if ({out_valid, out_src, in_ready} !== {1'b1, 2'd2, 4'b0}) begin
            err++; $display("FAIL mid_hold: got v=%b s=%0d rdy=%b, required 1/2/0000", out_valid, out_src, in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        #1;
        cmp++;
        if ({out_valid, in_ready} !== 5'b0) begin
            err++; $display("FAIL mid_reset: got v=%b rdy=%b, required 0/0000", out_valid, in_ready);
        end
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1; in_valid = 4'hF;
        #1;
        cmp++;
        if (in_ready !== 4'b0001) begin
            err++; $display("FAIL mid_restart: got %b, required 0001", in_ready);
        end
        sb.push_back({2'd0, 8'h40});
        @(negedge clk);
        in_valid = '0;
    endtask

    task automatic test_n5();
        @(negedge clk);
        mode5 = 1'b0; sel5 = 3'd4; v5 = 5'h1F; or5 = 1'b1;
        for (int j = 0; j < 5; j++) d5[j] = 8'h50 + 8'(j);
        #1;
        cmp++;
        if (r5 !== 5'b10000) begin
            err++; $display("FAIL n5_sel4: got %b, required 10000", r5);
        end
        for (int s = 5; s < 8; s++) begin
            @(negedge clk);
            sel5 = 3'(s);
            #1;
            cmp++;
            if (r5 !== 5'b0) begin
                err++; $display("FAIL n5_sel%0d: got %b, required 00000", s, r5);
            end
            cmp++;
            if ({ov5, od5, os5} !== {(s == 5), 8'h54, 3'd4}) begin
                err++; $display("FAIL n5_out%0d: got v=%b d=%h s=%0d, required %0d/54/4", s, ov5, od5, os5, s == 5);
            end
        end
        @(negedge clk);
        mode5 = 1'b1; v5 = 5'b10001;
        #1;
        cmp++;
        if (r5 !== 5'b00001) begin
            err++; $display("FAIL n5_wrap: got %b, required 00001", r5);
        end
        @(negedge clk);
        v5 = '0;
        #1;
        cmp++;
        if ({ov5, od5, os5} !== {1'b1, 8'h50, 3'd0}) begin
            err++; $display("FAIL n5_wrapout: got v=%b d=%h s=%0d, required 1/50/0", ov5, od5, os5);
        end
    endtask

    task automatic test_random();
        logic [1:0] m_ptr;
        logic       m_ov;
        logic       ld, g_ok;
        logic [1:0] g, idx;
        logic [3:0] er;
        do_reset();
        m_ptr = 2'd3;
        m_ov = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            mode = 1'($urandom); sel = 2'($urandom); in_valid = 4'($urandom);
            in_data = $urandom; out_ready = ($urandom_range(0, 3) != 0);
            #1;
            cmp++;
            if (out_valid !== m_ov) begin
                err++; $display("FAIL rand_ovalid[%0d]: got %b, required %b", c, out_valid, m_ov);
            end
            ld = !m_ov || out_ready;
            g_ok = 1'b0;
            g = '0;
            if (mode) begin
                for (int k = 1; k <= 4; k++) begin
                    idx = 2'((int'(m_ptr) + k) % 4);
                    if (!g_ok && in_valid[idx]) begin g_ok = 1'b1; g = idx; end
                end
            end else if (in_valid[sel]) begin
                g_ok = 1'b1; g = sel;
            end
            er = (g_ok && ld) ? (4'b0001 << g) : 4'b0;
            cmp++;
            if (in_ready !== er) begin
                err++; $display("FAIL rand_ready[%0d]: got %b, required %b", c, in_ready, er);
            end
            if (ld) m_ov = g_ok;
            if (g_ok && ld) begin
                m_ptr = g;
                sb.push_back({g, in_data[g]});
            end
        end
        @(negedge clk);
        in_valid = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        cmp++;
        if (sb.size() != 0) begin
            err++; $display("FAIL rand_drain: got %0d beats pending, required 0", sb.size());
        end
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        mode5 = 1'b0; sel5 = '0; v5 = '0; d5 = '0; or5 = 1'b0;
        test_reset();
        test_direct();
        test_rr();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_n5();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
